// File: rtl/flt_mult_hs.sv
// rtl/flt_mult_hs.sv - 3-stage pipelined floating-point multiplier with valid/ready handshake.
// Define FLT_MULT_SPECIAL_EN to treat the all-ones exponent as inf/NaN.
module flt_mult_hs #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_fl,
  output logic                     out_ovf,
  output logic                     out_unf
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int TW   = MAN_W + 3;
  localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
  localparam logic [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  logic [PW-1:0] prod;
  logic [TW-1:0] s0_top_d;
  logic [EW-1:0] s0_exp_d;
  logic          s0_zero_d, s0_nan_d, s0_inf_d;

  assign prod      = PW'({1'b1, fa}) * PW'({1'b1, fb});
  // Only the bits from the lowest possible guard position upward matter.
  assign s0_top_d  = TW'(prod >> (MAN_W - 1));
  assign s0_exp_d  = EW'(ea) + EW'(eb) - EW'(BIAS);
  assign s0_zero_d = (ea == '0) | (eb == '0);

`ifdef FLT_MULT_SPECIAL_EN
  logic a_max, b_max;
  assign a_max    = &ea;
  assign b_max    = &eb;
  assign s0_nan_d = (a_max & (|fa)) | (b_max & (|fb)) |
                    (a_max & (eb == '0)) | (b_max & (ea == '0));
  assign s0_inf_d = a_max | b_max;
`else
  assign s0_nan_d = 1'b0;
  assign s0_inf_d = 1'b0;
`endif

  logic          s0_valid_q, s0_sign_q, s0_zero_q, s0_nan_q, s0_inf_q;
  logic [TW-1:0] s0_top_q;
  logic [EW-1:0] s0_exp_q;

  logic             msb, guard, carry;
  logic [MAN_W:0]   mant_raw;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] s1_frac_d;
  logic [EW-1:0]    s1_exp_d;

  assign msb      = s0_top_q[TW-1];
  assign mant_raw = msb ? s0_top_q[TW-1 -: MAN_W+1] : s0_top_q[TW-2 -: MAN_W+1];
  assign guard    = msb ? s0_top_q[1] : s0_top_q[0];
  assign rnd      = {1'b0, mant_raw} + (MAN_W+2)'(guard);
  // A rounding carry leaves rnd = 10..0, so the truncated fraction is already zero.
  assign carry     = rnd[MAN_W+1];
  assign s1_frac_d = MAN_W'(rnd);
  assign s1_exp_d  = s0_exp_q + EW'(msb) + EW'(carry);

  logic             s1_valid_q, s1_sign_q, s1_zero_q, s1_nan_q, s1_inf_q;
  logic [MAN_W-1:0] s1_frac_q;
  logic [EW-1:0]    s1_exp_q;

  logic [W-1:0] fl_d;
  logic         ovf_d, unf_d, e_ovf, e_unf;

  assign e_ovf = ~s1_exp_q[EW-1] & (s1_exp_q >= EMAX);
  assign e_unf = s1_exp_q[EW-1] | (s1_exp_q == '0);

  always_comb begin
    fl_d  = {s1_sign_q, s1_exp_q[EXP_W-1:0], s1_frac_q};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s1_nan_q) begin
      fl_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s1_inf_q) begin
      fl_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_zero_q) begin
      fl_d = {s1_sign_q, {(W-1){1'b0}}};
    end else if (e_ovf) begin
      fl_d  = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (e_unf) begin
      fl_d  = {s1_sign_q, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end
  end

  logic         out_valid_q, out_ovf_q, out_unf_q;
  logic [W-1:0] out_fl_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_valid_q  <= 1'b0;
      s0_sign_q   <= 1'b0;
      s0_zero_q   <= 1'b0;
      s0_nan_q    <= 1'b0;
      s0_inf_q    <= 1'b0;
      s0_top_q    <= '0;
      s0_exp_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_frac_q   <= '0;
      s1_exp_q    <= '0;
      out_valid_q <= 1'b0;
      out_fl_q    <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else if (en) begin
      s0_valid_q  <= in_valid;
      s0_sign_q   <= sa ^ sb;
      s0_zero_q   <= s0_zero_d;
      s0_nan_q    <= s0_nan_d;
      s0_inf_q    <= s0_inf_d;
      s0_top_q    <= s0_top_d;
      s0_exp_q    <= s0_exp_d;
      s1_valid_q  <= s0_valid_q;
      s1_sign_q   <= s0_sign_q;
      s1_zero_q   <= s0_zero_q;
      s1_nan_q    <= s0_nan_q;
      s1_inf_q    <= s0_inf_q;
      s1_frac_q   <= s1_frac_d;
      s1_exp_q    <= s1_exp_d;
      out_valid_q <= s1_valid_q;
      out_fl_q    <= fl_d;
      out_ovf_q   <= s1_valid_q & ovf_d;
      out_unf_q   <= s1_valid_q & unf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_fl    = out_fl_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;
endmodule
